reg_port_seq: RTL

Sequencer that sits directly upstream of the six-entry, 20-bit general register file and owns its single access port. It accepts one instruction-level request at a time, reads source operands A and B over consecutive cycles, and presents them to the execute stage. When the request expects a result, it then waits for write-back data and performs one register write. Only this block drives the register file's select, address and write-data lines.

---
 rtl/reg_port_seq_pkg.sv | 31 +++
 rtl/reg_port_seq_fmt.sv | 17 +
 rtl/reg_port_seq.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/reg_port_seq_pkg.sv
// Shared definitions for the register-file port sequencer:
// geometry, access-width encodings and the sequencer state set.
package reg_port_seq_pkg;

    localparam int NUM_REGS = 6;
    localparam int DATA_W   = 20;
    localparam int HALF_W   = 10;
    localparam int ADDR_W   = 3;

    typedef enum logic [1:0] {
        SEL_FULL = 2'b00,
        SEL_HI   = 2'b01,
        SEL_LO   = 2'b10,
        SEL_NONE = 2'b11
    } sel_e;

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_B,
        CAP_B,
        OPND,
        WAIT_WB,
        WR
    } state_e;

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return a < ADDR_W'(NUM_REGS);
    endfunction

endpackage

// File: rtl/reg_port_seq_fmt.sv
// Width formatter: passes a full word through, otherwise keeps the
// low half-word and zero-fills the upper bits.
module reg_port_fmt
    import reg_port_seq_pkg::*;
(
    input  logic [1:0]        sel,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    always_comb begin
        dout = {{(DATA_W-HALF_W){1'b0}}, din[HALF_W-1:0]};
        if (sel == SEL_FULL)
            dout = din;
    end

endmodule

// File: rtl/reg_port_seq.sv
// Sequencer owning the single register-file port: reads two operands,
// hands them to execute, then optionally writes one result back.
module reg_port_seq
    import reg_port_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_sel,
    input  logic [ADDR_W-1:0] req_src_a,
    input  logic [ADDR_W-1:0] req_src_b,
    input  logic [ADDR_W-1:0] req_dst,
    input  logic              req_wb,
    output logic              err,
    output logic              opnd_valid,
    input  logic              opnd_ready,
    output logic [DATA_W-1:0] opnd_a,
    output logic [DATA_W-1:0] opnd_b,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [DATA_W-1:0] wb_data,
    output logic [1:0]        rf_addr_sel,
    output logic [ADDR_W-1:0] rf_addr,
    output logic              rf_we,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [DATA_W-1:0] rf_rdata
);

    state_e            state;
    logic [1:0]        sel_q;
    logic [ADDR_W-1:0] src_b_q;
    logic [ADDR_W-1:0] dst_q;
    logic              wb_q;
    logic [DATA_W-1:0] rd_fmt;
    logic [DATA_W-1:0] wr_fmt;
    logic              illegal;

    reg_port_fmt u_rd_fmt (
        .sel  (sel_q),
        .din  (rf_rdata),
        .dout (rd_fmt)
    );

    reg_port_fmt u_wr_fmt (
        .sel  (sel_q),
        .din  (wb_data),
        .dout (wr_fmt)
    );

    // Destination only matters when a write-back will actually happen
    assign illegal = (req_sel == SEL_NONE)
                   || !addr_ok(req_src_a)
                   || !addr_ok(req_src_b)
                   || (req_wb && !addr_ok(req_dst));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sel_q       <= SEL_NONE;
            src_b_q     <= '0;
            dst_q       <= '0;
            wb_q        <= 1'b0;
            req_ready   <= 1'b1;
            err         <= 1'b0;
            opnd_valid  <= 1'b0;
            opnd_a      <= '0;
            opnd_b      <= '0;
            wb_ready    <= 1'b0;
            rf_we       <= 1'b0;
            rf_addr_sel <= SEL_NONE;
            rf_addr     <= '0;
            rf_wdata    <= '0;
        end else begin
            err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (illegal) begin
                            err <= 1'b1;
                        end else begin
                            sel_q       <= req_sel;
                            src_b_q     <= req_src_b;
                            dst_q       <= req_dst;
                            wb_q        <= req_wb;
                            rf_addr     <= req_src_a;
                            rf_addr_sel <= req_sel;
                            req_ready   <= 1'b0;
                            state       <= RD_A;
                        end
                    end
                end
                RD_A: begin
                    rf_addr <= src_b_q;
                    state   <= RD_B;
                end
                // Read data lags the address by one cycle
                RD_B: begin
                    opnd_a      <= rd_fmt;
                    rf_addr_sel <= SEL_NONE;
                    state       <= CAP_B;
                end
                CAP_B: begin
                    opnd_b     <= rd_fmt;
                    opnd_valid <= 1'b1;
                    state      <= OPND;
                end
                OPND: begin
                    if (opnd_ready) begin
                        opnd_valid <= 1'b0;
                        if (wb_q) begin
                            wb_ready <= 1'b1;
                            state    <= WAIT_WB;
                        end else begin
                            req_ready <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                end
                WAIT_WB: begin
                    if (wb_valid) begin
                        wb_ready    <= 1'b0;
                        rf_wdata    <= wr_fmt;
                        rf_we       <= 1'b1;
                        rf_addr     <= dst_q;
                        rf_addr_sel <= sel_q;
                        state       <= WR;
                    end
                end
                WR: begin
                    rf_we       <= 1'b0;
                    rf_addr_sel <= SEL_NONE;
                    req_ready   <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
